// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch stage drives req/addr; memory answers with gnt, then rvalid/rdata.
interface fetch_if;
   logic        f_imem_req_o;
   logic [63:0] f_imem_addr_o;
   logic        f_imem_gnt_i;
   logic        f_imem_rvalid_i;
   logic [31:0] f_imem_rdata_i;

   modport master (
      output f_imem_req_o, f_imem_addr_o,
      input  f_imem_gnt_i, f_imem_rvalid_i, f_imem_rdata_i
   );

   modport slave (
      input  f_imem_req_o, f_imem_addr_o,
      output f_imem_gnt_i, f_imem_rvalid_i, f_imem_rdata_i
   );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding imem requester feeding a small FIFO to decode,
// with redirect handling that drops wrong-path responses still in flight.
module fetch #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_if.master     imem,
   input  logic        f_stall_i,
   input  logic        f_branch_i,
   input  logic [63:0] f_pc_b_i,
   input  logic        f_jump_jal_i,
   input  logic [63:0] f_pc_jal_i,
   input  logic        f_jump_jalr_i,
   input  logic [63:0] f_pc_jalr_i,
   output logic        f_valid_o,
   output logic [31:0] f_instr_o,
   output logic [63:0] f_pc_o,
   output logic        f_misalign_o
);

   localparam int          PW  = $clog2(BUF_DEPTH);
   localparam int          CW  = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_e        state_q, state_d;
   logic [63:0]   pc_q, pc_d;
   logic [63:0]   addr_q, addr_d;
   logic [63:0]   rsp_pc_q, last_pc_q, target;
   logic          discard_q, discard_d;
   logic          mis_q;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   entry_t        buf_q [BUF_DEPTH];
   entry_t        head;
   logic          valid, pop, redir, push, gnt, rvalid;

   assign gnt    = imem.f_imem_gnt_i;
   assign rvalid = imem.f_imem_rvalid_i;
   assign valid  = (cnt_q != '0);
   assign head   = buf_q[rd_q];
   assign pop    = valid && !f_stall_i;
   // Decode operands are only trustworthy while it is actually consuming the head.
   assign redir  = pop && (f_branch_i || f_jump_jal_i || f_jump_jalr_i);
   assign target = f_branch_i   ? f_pc_b_i   :
                   f_jump_jal_i ? f_pc_jal_i : f_pc_jalr_i;
   assign push   = (state_q == WAIT) && rvalid && !discard_q && !redir;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      if (redir) begin
         rd_d  = wr_q;
         cnt_d = '0;
      end else begin
         rd_d  = rd_q + PW'(pop);
         wr_d  = wr_q + PW'(push);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
      unique case (state_q)
         IDLE: if (cnt_d < CW'(BUF_DEPTH)) state_d = REQ;
         REQ: begin
            if (redir) discard_d = 1'b1;
            if (gnt) begin
               state_d = WAIT;
               // a grant that will be discarded does not advance the fetch PC
               if (!discard_q && !redir) pc_d = pc_q + 64'd4;
            end
         end
         WAIT: begin
            if (rvalid) begin
               discard_d = 1'b0;
               state_d   = (cnt_d < CW'(BUF_DEPTH)) ? REQ : IDLE;
            end else if (redir) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redir) pc_d = {target[63:2], 2'b00};
      // an ungranted request keeps its address even across a redirect
      addr_d = (state_q == REQ && !gnt) ? addr_q : pc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         rsp_pc_q  <= RESET_PC;
         last_pc_q <= RESET_PC;
         discard_q <= 1'b0;
         mis_q     <= 1'b0;
         rd_q      <= '0;
         wr_q      <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         discard_q <= discard_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         mis_q     <= redir && (target[1:0] != 2'b00);
         if (state_q == REQ && gnt) rsp_pc_q <= addr_q;
         if (valid) last_pc_q <= head.pc;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_q[wr_q] <= '{pc: rsp_pc_q, instr: imem.f_imem_rdata_i};
   end

   assign imem.f_imem_req_o  = (state_q == REQ);
   assign imem.f_imem_addr_o = addr_q;
   assign f_valid_o          = valid;
   assign f_instr_o          = valid ? head.instr : NOP;
   assign f_pc_o             = valid ? head.pc : last_pc_q;
   assign f_misalign_o       = mis_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a reactive imem model, a program-order scoreboard checked every cycle,
// and directed scenarios with literal expectations.
module tb_fetch;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_if mif();

   logic        stall, br, jal, jalr;
   logic [63:0] pc_b, pc_jal, pc_jalr;
   logic        valid, mis;
   logic [31:0] instr;
   logic [63:0] pc;

   fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .imem(mif),
      .f_stall_i(stall),
      .f_branch_i(br), .f_pc_b_i(pc_b),
      .f_jump_jal_i(jal), .f_pc_jal_i(pc_jal),
      .f_jump_jalr_i(jalr), .f_pc_jalr_i(pc_jalr),
      .f_valid_o(valid), .f_instr_o(instr), .f_pc_o(pc), .f_misalign_o(mis)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_req = -1;
   int first_val = -1;

   function automatic logic [31:0] ins_of(input logic [63:0] a);
      return {a[31:2], 2'b11} ^ 32'h0F0F_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // imem: gnt whenever enabled, rdata = ins_of(addr) 'lat' cycles after the grant
   int          lat = 1;
   logic        gnt_en = 1'b1;
   logic        p_vld = 1'b0;
   logic [63:0] p_addr = '0;
   int          p_left = 0;
   logic [63:0] glog[$];

   always @(posedge clk) begin : mem_p
      logic        g;
      logic [63:0] a;
      g = mif.f_imem_req_o && mif.f_imem_gnt_i;
      a = mif.f_imem_addr_o;
      #2;
      if (g) begin
         p_vld = 1'b1; p_addr = a; p_left = lat; glog.push_back(a);
      end
      mif.f_imem_rvalid_i = 1'b0;
      mif.f_imem_rdata_i  = 32'h0;
      if (p_vld) begin
         if (p_left <= 1) begin
            mif.f_imem_rvalid_i = 1'b1;
            mif.f_imem_rdata_i  = ins_of(p_addr);
            p_vld = 1'b0;
         end else p_left--;
      end
      mif.f_imem_gnt_i = mif.f_imem_req_o && gnt_en;
   end

   // scoreboard: decode must see program order from RESET_PC, following accepted redirects
   logic [63:0] exp_pc = RST_PC, last_pc = RST_PC, prev_addr = '0, tgt;
   logic        exp_mis = 1'b0, prev_pend = 1'b0;

   always @(negedge clk) begin : scb_p
      if (!rst_n) begin
         chk("rst_req", 64'(mif.f_imem_req_o), 64'd0);
         chk("rst_addr", mif.f_imem_addr_o, RST_PC);
         chk("rst_valid", 64'(valid), 64'd0);
         chk("rst_instr", 64'(instr), 64'(NOP));
         chk("rst_pc", pc, RST_PC);
         chk("rst_mis", 64'(mis), 64'd0);
         exp_pc = RST_PC; last_pc = RST_PC; exp_mis = 1'b0; prev_pend = 1'b0;
      end else begin
         if (first_req < 0 && mif.f_imem_req_o) first_req = cyc;
         if (first_val < 0 && valid) first_val = cyc;
         chk("misalign", 64'(mis), 64'(exp_mis));
         exp_mis = 1'b0;
         if (prev_pend) begin
            chk("req_held", 64'(mif.f_imem_req_o), 64'd1);
            chk("addr_held", mif.f_imem_addr_o, prev_addr);
         end
         if (mif.f_imem_req_o) chk("addr_align", 64'(mif.f_imem_addr_o[1:0]), 64'd0);
         if (mif.f_imem_req_o && mif.f_imem_gnt_i) chk("one_outstanding", 64'(p_vld), 64'd0);
         if (valid) begin
            chk("pc", pc, exp_pc);
            chk("instr", 64'(instr), 64'(ins_of(exp_pc)));
            last_pc = pc;
            if (!stall) begin
               if (br || jal || jalr) begin
                  tgt     = br ? pc_b : (jal ? pc_jal : pc_jalr);
                  exp_pc  = {tgt[63:2], 2'b00};
                  exp_mis = (tgt[1:0] != 2'b00);
               end else exp_pc = exp_pc + 64'd4;
            end
         end else begin
            chk("nop_when_invalid", 64'(instr), 64'(NOP));
            chk("pc_hold", pc, last_pc);
         end
         prev_pend = mif.f_imem_req_o && !mif.f_imem_gnt_i;
         prev_addr = mif.f_imem_addr_o;
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_valid(input string name, input int bound);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (valid) begin ok = 1'b1; break; end
         step(1);
      end
      chk(name, 64'(ok), 64'd1);
   endtask

   task automatic fill();
      stall = 1'b1;
      step(4);
      chk("fill_req_off", 64'(mif.f_imem_req_o), 64'd0);
      chk("fill_valid", 64'(valid), 64'd1);
   endtask

   task automatic redirect(input logic b, input logic j, input logic jr,
                           input logic [63:0] tb_, input logic [63:0] tj, input logic [63:0] tjr);
      stall = 1'b1;
      wait_valid("redir_ready", 20);
      stall = 1'b0; br = b; jal = j; jalr = jr;
      pc_b = tb_; pc_jal = tj; pc_jalr = tjr;
      step(1);
      br = 1'b0; jal = 1'b0; jalr = 1'b0;
   endtask

   initial begin : stim
      logic [63:0] stale;
      logic        found;
      int          n0;
      rst_n = 1'b0; stall = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
      pc_b = '0; pc_jal = '0; pc_jalr = '0;
      step(2);
      rst_n = 1'b1;

      // sequential fetch, gnt same cycle, rvalid next cycle
      step(14);
      chk("valid_latency", 64'(first_val - first_req), 64'd2);
      chk("glog_len", 64'(glog.size() >= 3), 64'd1);
      if (glog.size() >= 3) begin
         chk("req0", glog[0], 64'h8000_0000);
         chk("req1", glog[1], 64'h8000_0004);
         chk("req2", glog[2], 64'h8000_0008);
      end

      // stall fills the FIFO and stops requesting
      fill();
      step(1); stall = 1'b0;
      step(6);

      // branch accepted while a response is outstanding in WAIT
      fill();
      lat = 2; stall = 1'b0;
      step(1); stall = 1'b1;
      step(1);
      chk("t3_in_wait", 64'(mif.f_imem_req_o), 64'd0);
      chk("t3_valid", 64'(valid), 64'd1);
      stall = 1'b0; br = 1'b1; pc_b = 64'h8000_0100;
      step(1); br = 1'b0;
      wait_valid("t3_wait", 20);
      chk("t3_target", pc, 64'h8000_0100);

      // jal accepted while a request sits ungranted
      lat = 1;
      fill();
      gnt_en = 1'b0; stall = 1'b0;
      step(1); stall = 1'b1;
      stale = mif.f_imem_addr_o;
      chk("t4_req", 64'(mif.f_imem_req_o), 64'd1);
      step(3);
      chk("t4_addr_a", mif.f_imem_addr_o, stale);
      stall = 1'b0; jal = 1'b1; pc_jal = 64'h8000_0200;
      step(1); jal = 1'b0;
      chk("t4_addr_b", mif.f_imem_addr_o, stale);
      n0 = glog.size();
      gnt_en = 1'b1;
      wait_valid("t4_wait", 20);
      chk("t4_target", pc, 64'h8000_0200);
      chk("t4_glog_len", 64'(glog.size() >= n0 + 2), 64'd1);
      if (glog.size() >= n0 + 2) begin
         chk("t4_stale_granted", glog[n0], stale);
         chk("t4_next_req", glog[n0+1], 64'h8000_0200);
      end

      // priority and misalignment
      redirect(1'b1, 1'b0, 1'b1, 64'h8000_0400, 64'h0, 64'h8000_0302);
      chk("t5_mis_branch", 64'(mis), 64'd0);
      wait_valid("t5_wait_a", 20);
      chk("t5_branch_wins", pc, 64'h8000_0400);
      redirect(1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h8000_0302);
      chk("t5_mis_pulse", 64'(mis), 64'd1);
      step(1);
      chk("t5_mis_clear", 64'(mis), 64'd0);
      wait_valid("t5_wait_b", 20);
      chk("t5_jalr_aligned", pc, 64'h8000_0300);

      // PC wraps modulo 2^64
      redirect(1'b0, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid && pc == 64'h0) begin found = 1'b1; break; end
         step(1);
      end
      chk("wrap_to_zero", 64'(found), 64'd1);

      // async reset in WAIT, late rvalid must be ignored
      lat = 2;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #3;
         if (mif.f_imem_req_o && mif.f_imem_gnt_i) begin found = 1'b1; break; end
      end
      chk("t6_grant_seen", 64'(found), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_req", 64'(mif.f_imem_req_o), 64'd0);
      chk("t6_addr", mif.f_imem_addr_o, RST_PC);
      chk("t6_valid", 64'(valid), 64'd0);
      chk("t6_instr", 64'(instr), 64'(NOP));
      chk("t6_pc", pc, RST_PC);
      chk("t6_mis", 64'(mis), 64'd0);
      #5;
      rst_n = 1'b1;
      step(1);
      wait_valid("t6_wait", 20);
      chk("t6_restart_pc", pc, RST_PC);
      chk("t6_restart_instr", 64'(instr), 64'(ins_of(RST_PC)));
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #300000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage; produces the instruction/PC pair consumed by the decode stage.
- Keeps the fetch PC and drives a req/gnt/rvalid handshake to instruction memory.
- Buffers returned instructions in a small FIFO.
- Applies branch/jal/jalr redirects from decode and discards wrong-path responses still in flight.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f_imem_req_o  output  1  fetch request valid.
- f_imem_addr_o  output  64  fetch address, always word aligned.
- f_imem_gnt_i  input  1  memory accepted request this cycle.
- f_imem_rvalid_i  input  1  response data valid.
- f_imem_rdata_i  input  32  response instruction.
- f_stall_i  input  1  pipe control holds decode; FIFO head not consumed.
- f_branch_i  input  1  taken conditional branch in decode.
- f_pc_b_i  input  64  branch target.
- f_jump_jal_i  input  1  jal in decode.
- f_pc_jal_i  input  64  jal target.
- f_jump_jalr_i  input  1  jalr in decode.
- f_pc_jalr_i  input  64  jalr target, bit0 already cleared.
- f_valid_o  output  1  f_instr_o/f_pc_o hold a real instruction.
- f_instr_o  output  32  instruction to decode; 32'h0000_0013 (NOP) when f_valid_o=0.
- f_pc_o  output  64  PC of f_instr_o; holds last value when invalid.
- f_misalign_o  output  1  one-cycle pulse: accepted redirect target had bits[1:0]!=0.

Behaviour:
- Reset (async, rst_n=0) sets:
  - fetch PC=RESET_PC; f_imem_addr_o=RESET_PC.
  - f_imem_req_o=0, f_valid_o=0, f_instr_o=NOP, f_pc_o=RESET_PC, f_misalign_o=0.
  - FIFO empty, discard flag clear, FSM=IDLE.
- FSM states:
  - IDLE: go to REQ when (FIFO count + outstanding) < BUF_DEPTH; first request is the cycle after rst_n rises.
  - REQ: req=1, addr=fetch PC. On gnt: go to WAIT and set fetch PC += 4.
  - WAIT: on rvalid:
    - If discard is set, drop the data and clear discard.
    - Otherwise push {fetch address, rdata} into the FIFO.
    - Then go to REQ if space remains, else IDLE. The new request may assert in the same cycle as rvalid.
- Request rules:
  - At most one outstanding request.
  - req and addr must stay stable from assertion until gnt; neither redirect nor stall withdraws or changes them.
  - rvalid is never earlier than the cycle after gnt.
  - rvalid outside WAIT is ignored.
- Consume: the FIFO head is popped when f_valid_o=1 && f_stall_i=0. Outputs are combinational from the FIFO head.
- Redirect:
  - Accepted only when f_valid_o=1 && f_stall_i=0. It is ignored while stalled or invalid, because decode operands are not yet valid then.
  - Target priority: f_branch_i > f_jump_jal_i > f_jump_jalr_i.
  - On acceptance, next cycle: FIFO flushed; fetch PC = {target[63:2],2'b00}; f_misalign_o=1 if target[1:0]!=0.
  - In REQ at acceptance: the stale request completes its handshake, discard is set, and after gnt the FSM goes to WAIT and then REQ with the new PC. Fetch PC is not incremented for the discarded grant.
  - In WAIT at acceptance: discard is set.
  - In IDLE at acceptance: go to REQ with the target next cycle.
  - A response arriving in the same cycle as an accepted redirect is discarded.
- Push and pop in the same cycle: allowed, count unchanged. Pop of the last entry with a simultaneous push keeps f_valid_o=1 next cycle.
- Full FIFO: no new request; an in-flight response always fits because issue accounts for outstanding requests.
- Arithmetic: fetch PC wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).

Test Plan:
- Reset, memory gnt same cycle and rvalid next cycle, f_stall_i=0:
  - Addresses 0x8000_0000, _0004, _0008 are requested in sequence.
  - f_valid_o rises 2 cycles after the first req.
  - f_pc_o steps by 4 with matching instructions.
- Hold f_stall_i=1 for 5 cycles:
  - FIFO fills to 2 and req drops.
  - f_instr_o/f_pc_o stay constant.
  - On release, entries are consumed in order and no instruction is lost or duplicated.
- f_branch_i=1, f_pc_b_i=0x8000_0100, accepted while a request is in WAIT:
  - The in-flight response is dropped.
  - Next valid f_pc_o=0x8000_0100.
  - No wrong-path instruction reaches f_valid_o.
- Hold gnt low 3 cycles, then assert f_jump_jal_i with target 0x8000_0200:
  - Addr stays at the stale value until gnt.
  - That response is discarded; the next request is 0x8000_0200.
- Assert f_jump_jalr_i target 0x8000_0302 together with f_branch_i target 0x8000_0400:
  - Branch wins; fetch 0x8000_0400; no misalign.
  - Then jalr alone with 0x8000_0302: fetch 0x8000_0300, f_misalign_o pulses 1 cycle.
- Pull rst_n low mid-WAIT, then release:
  - All outputs return to reset values asynchronously.
  - A late rvalid is ignored.
  - The fetch restarts at RESET_PC.
